// File: rtl/instr_encoder.sv
// instr_encoder: RV32 field-bundle encoder with immediate-range rejection, 2-entry output FIFO and output address counter
module instr_encoder #(
  parameter logic [31:0] RESET_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  input  logic        base_load,
  input  logic [31:0] base_addr,
  output logic        err,
  output logic [7:0]  err_cnt
);
  logic signed [31:0] simm;
  logic               fits12, fits13, fits21, bad, acc, push, pop, ready_en, wr_ptr, rd_ptr;
  logic [1:0]         count;
  logic [31:0]        enc, addr;
  logic [31:0]        mem [2];
  assign simm      = in_imm;
  assign fits12    = simm >= -32'sd2048 && simm <= 32'sd2047;
  assign fits13    = simm >= -32'sd4096 && simm <= 32'sd4095;
  assign fits21    = simm >= -32'sd1048576 && simm <= 32'sd1048575;
  assign in_ready  = ready_en && count < 2'd2;
  assign acc       = in_valid && in_ready;
  assign push      = acc && !bad;
  assign out_valid = count != 2'd0;
  assign pop       = out_valid && out_ready;
  assign out_instr = out_valid ? mem[rd_ptr] : 32'h0;
  assign out_addr  = addr;
  always_comb begin
    bad = in_fmt == 3'd1 || in_fmt == 3'd2 ? !fits12 :
          in_fmt == 3'd3 ? !fits13 || in_imm[0] :
          in_fmt == 3'd4 ? |in_imm[11:0] :
          in_fmt == 3'd5 ? !fits21 || in_imm[0] :
          in_fmt > 3'd5;
    enc = in_fmt == 3'd0 ? {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode} :
          in_fmt == 3'd1 ? {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode} :
          in_fmt == 3'd2 ? {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode} :
          in_fmt == 3'd3 ? {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], in_opcode} :
          in_fmt == 3'd4 ? {in_imm[31:12], in_rd, in_opcode} :
          {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      addr     <= RESET_BASE;
      err      <= 1'b0;
      err_cnt  <= 8'd0;
    end else begin
      ready_en <= 1'b1;
      count    <= count + {1'b0, push} - {1'b0, pop};
      wr_ptr   <= wr_ptr ^ push;
      rd_ptr   <= rd_ptr ^ pop;
      addr     <= base_load ? base_addr : pop ? addr + 32'd4 : addr;
      err      <= acc && bad;
      err_cnt  <= acc && bad && err_cnt != 8'hFF ? err_cnt + 8'd1 : err_cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc;
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed self-checking bench for instr_encoder
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, base_load, err;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_instr, out_addr, base_addr;
  logic [7:0]  err_cnt;
  int          checks = 0;
  int          errors = 0;
  localparam logic [31:0] W1 = 32'h003100B3;
  localparam logic [31:0] W2 = 32'h40628233;
  localparam logic [31:0] W3 = 32'h123452B7;
  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr), .base_load(base_load),
    .base_addr(base_addr), .err(err), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic set_bundle(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
  endtask
  task automatic push_w1;
    set_bundle(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'h0);
  endtask
  task automatic push_w2;
    set_bundle(3'd0, 7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 7'h20, 32'h0);
  endtask
  task automatic test_reset;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; base_load = 1'b0; base_addr = 32'h0;
    set_bundle(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
    checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL reset_out_addr got %h want 0", out_addr); end
    checks++; if (err !== 1'b0 || err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err got %b/%0d want 0/0", err, err_cnt); end
    rst_n = 1'b1;
    tick;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
  endtask
  task automatic test_itype;
    out_ready = 1'b0;
    set_bundle(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd5);
    tick;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL itype_valid got %b want 1", out_valid); end
    checks++; if (out_instr !== 32'h00500093) begin errors++; $display("FAIL itype_instr got %h want 00500093", out_instr); end
    checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL itype_addr got %h want 0", out_addr); end
    out_ready = 1'b1;
    tick;
    checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0) begin errors++; $display("FAIL itype_drain got %b/%h want 0/0", out_valid, out_instr); end
    checks++; if (out_addr !== 32'h4) begin errors++; $display("FAIL itype_addr_inc got %h want 4", out_addr); end
  endtask
  task automatic test_backpressure;
    out_ready = 1'b0; base_load = 1'b1; base_addr = 32'h0;
    tick;
    base_load = 1'b0;
    checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL bp_base got %h want 0", out_addr); end
    push_w1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b want 1", in_ready); end
    tick;
    checks++; if (out_valid !== 1'b1 || out_instr !== W1) begin errors++; $display("FAIL bp_first got %b/%h want 1/%h", out_valid, out_instr, W1); end
    push_w2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready2 got %b want 1", in_ready); end
    tick;
    set_bundle(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h0, 32'h12345000);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
    tick;
    checks++; if (in_ready !== 1'b0 || out_instr !== W1) begin errors++; $display("FAIL bp_hold got %b/%h want 0/%h", in_ready, out_instr, W1); end
    checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL bp_addr0 got %h want 0", out_addr); end
    out_ready = 1'b1;
    tick;
    checks++; if (out_instr !== W2 || out_addr !== 32'h4) begin errors++; $display("FAIL bp_pop2 got %h@%h want %h@4", out_instr, out_addr, W2); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready3 got %b want 1", in_ready); end
    tick;
    in_valid = 1'b0;
    checks++; if (out_instr !== W3 || out_addr !== 32'h8) begin errors++; $display("FAIL bp_pop3 got %h@%h want %h@8", out_instr, out_addr, W3); end
    tick;
    checks++; if (out_valid !== 1'b0 || out_addr !== 32'hC) begin errors++; $display("FAIL bp_empty got %b@%h want 0@c", out_valid, out_addr); end
  endtask
  task automatic test_bj;
    out_ready = 1'b0;
    set_bundle(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h0, 32'hFFFF_FFFC);
    tick;
    set_bundle(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd8);
    checks++; if (out_instr !== 32'hFE208EE3) begin errors++; $display("FAIL btype got %h want fe208ee3", out_instr); end
    tick;
    in_valid = 1'b0;
    checks++; if (out_instr !== 32'hFE208EE3) begin errors++; $display("FAIL btype_stable got %h want fe208ee3", out_instr); end
    out_ready = 1'b1;
    tick;
    checks++; if (out_instr !== 32'h008000EF) begin errors++; $display("FAIL jtype got %h want 008000ef", out_instr); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bj_empty got %b want 0", out_valid); end
  endtask
  task automatic test_reject;
    logic [2:0]  rf [8];
    logic [31:0] ri [8];
    logic [2:0]  af [3];
    logic [4:0]  ard [3];
    logic [6:0]  aop [3];
    logic [31:0] ai [3];
    logic [31:0] ae [3];
    rf = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    ri = '{32'd2048, 32'hFFFF_F7FF, 32'd3, 32'd4096, 32'h0000_1001, 32'h0010_0000, 32'h0, 32'h0};
    af = '{3'd1, 3'd1, 3'd5};
    ard = '{5'd1, 5'd1, 5'd0};
    aop = '{7'h13, 7'h13, 7'h6F};
    ai = '{32'd2047, 32'hFFFF_F800, 32'hFFF0_0000};
    ae = '{32'h7FF00093, 32'h80000093, 32'h8000006F};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_bundle(rf[i], 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, ri[i]);
      tick;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL reject%0d got valid=%b err=%b want 0/1", i, out_valid, err); end
      checks++; if (err_cnt !== 8'(i + 1)) begin errors++; $display("FAIL reject%0d_cnt got %0d want %0d", i, err_cnt, i + 1); end
      tick;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reject%0d_pulse got %b want 0", i, err); end
    end
    for (int i = 0; i < 3; i++) begin
      set_bundle(af[i], aop[i], ard[i], 5'd0, 5'd0, 3'd0, 7'h0, ai[i]);
      tick;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_instr !== ae[i] || err !== 1'b0) begin errors++; $display("FAIL edge%0d got %b/%h/%b want 1/%h/0", i, out_valid, out_instr, err, ae[i]); end
      tick;
    end
    set_bundle(3'd6, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0);
    repeat (300) tick;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL stream_err got %b want 1", err); end
    in_valid = 1'b0;
    tick;
    checks++; if (err_cnt !== 8'd255 || err !== 1'b0) begin errors++; $display("FAIL saturate got %0d/%b want 255/0", err_cnt, err); end
  endtask
  task automatic test_base_load;
    out_ready = 1'b0;
    push_w1;
    tick;
    push_w2;
    tick;
    in_valid = 1'b0; out_ready = 1'b1; base_load = 1'b1; base_addr = 32'hFFFF_FFFC;
    tick;
    base_load = 1'b0;
    checks++; if (out_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL load_addr got %h want fffffffc", out_addr); end
    checks++; if (out_instr !== W2) begin errors++; $display("FAIL load_fifo got %h want %h", out_instr, W2); end
    tick;
    checks++; if (out_addr !== 32'h0 || out_valid !== 1'b0) begin errors++; $display("FAIL wrap got %h/%b want 0/0", out_addr, out_valid); end
  endtask
  task automatic test_reset_mid;
    out_ready = 1'b0; base_load = 1'b1; base_addr = 32'h100;
    tick;
    base_load = 1'b0;
    push_w1;
    tick;
    push_w2;
    tick;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_addr !== 32'h100) begin errors++; $display("FAIL pre_reset got %b/%b/%h want 1/0/100", out_valid, in_ready, out_addr); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0) begin errors++; $display("FAIL mid_reset_out got %b/%h want 0/0", out_valid, out_instr); end
    checks++; if (out_addr !== 32'h0 || err_cnt !== 8'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_state got %h/%0d/%b want 0/0/0", out_addr, err_cnt, in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL post_reset got %b/%b/%b want 0/1/0", out_valid, in_ready, err); end
  endtask
  initial begin
    test_reset;
    test_itype;
    test_backpressure;
    test_bj;
    test_reject;
    test_base_load;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
